// File: rtl/uart_cfg_pkg.sv
// Shared types, frame constants, baud table and field decoders for the UART
// configuration controller.
package uart_cfg_pkg;

  typedef enum logic [3:0] {
    ST_HDR0,
    ST_HDR1,
    ST_CHI,
    ST_CLO,
    ST_CHK,
    ST_TAIL,
    ST_WAIT_IDLE,
    ST_APPLY
  } cfg_state_e;

  localparam logic [7:0] SOF0 = 8'hAA;
  localparam logic [7:0] SOF1 = 8'h55;
  localparam logic [7:0] EOF  = 8'h55;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_CHECKSUM = 2'd1;
  localparam logic [1:0] ERR_FIELD    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [15:0] RST_BPS_DIV     = 16'd325;
  localparam logic [3:0]  RST_DATA_SIZE   = 4'd8;
  localparam logic [5:0]  RST_STOP_SIZE   = 6'd16;
  localparam logic [1:0]  RST_PARITY_MODE = 2'b00;

  // 16x-oversample divisors for a 50 MHz clock.
  localparam logic [15:0] BAUD_TABLE [16] = '{
    16'd28409, 16'd10416, 16'd5208, 16'd2604,
    16'd1302,  16'd651,   16'd325,  16'd217,
    16'd162,   16'd81,    16'd72,   16'd55,
    16'd54,    16'd27,    16'd24,   16'd12
  };

  function automatic logic [15:0] bps_lookup(input logic [3:0] idx);
    return BAUD_TABLE[idx];
  endfunction

  function automatic logic [3:0] data_size_of(input logic [1:0] width_code);
    return 4'd5 + {2'b00, width_code};
  endfunction

  function automatic logic [5:0] stop_size_of(input logic [1:0] stop_code);
    logic [5:0] ticks;
    case (stop_code)
      2'b00:   ticks = 6'd16;
      2'b01:   ticks = 6'd24;
      default: ticks = 6'd32;
    endcase
    return ticks;
  endfunction

endpackage

// File: rtl/uart_cfg_timer.sv
// Loadable saturating down-counter; expired is high while the count is zero.
module uart_cfg_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/uart_cfg_ctrl.sv
// Parses AA 55 CHI CLO CHK 55 control frames from the RX byte stream and
// applies the decoded UART configuration once TX and RX are both idle.
module uart_cfg_ctrl
  import uart_cfg_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT = 2_000_000,
  parameter int unsigned IDLE_TIMEOUT = 5_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        uart_idle,
  output logic        cfg_req,
  output logic [15:0] bps_div,
  output logic [3:0]  data_size,
  output logic [5:0]  stop_size,
  output logic [1:0]  parity_mode,
  output logic        cfg_update,
  output logic        cfg_error,
  output logic [1:0]  err_code
);

  localparam int unsigned BW = $clog2(BYTE_TIMEOUT + 1);
  localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);

  cfg_state_e  state_q, state_d;
  logic [7:0]  chi_q, chi_d, clo_q, clo_d, chk_q, chk_d;
  logic [15:0] bps_div_q, bps_div_d;
  logic [3:0]  data_size_q, data_size_d;
  logic [5:0]  stop_size_q, stop_size_d;
  logic [1:0]  parity_mode_q, parity_mode_d;
  logic        cfg_req_q, cfg_req_d;
  logic        cfg_update_q, cfg_update_d;
  logic        cfg_error_q, cfg_error_d;
  logic [1:0]  err_code_q, err_code_d;

  logic byte_load, byte_dec, byte_exp;
  logic idle_load, idle_dec, idle_exp;
  logic byte_timed;
  logic fields_bad;

  // Loaded with TIMEOUT-1 so the error fires exactly TIMEOUT cycles after the load.
  uart_cfg_timer #(.W(BW)) u_byte_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (byte_load),
    .load_val (BW'(BYTE_TIMEOUT - 1)),
    .dec      (byte_dec),
    .expired  (byte_exp)
  );

  uart_cfg_timer #(.W(IW)) u_idle_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (idle_load),
    .load_val (IW'(IDLE_TIMEOUT - 1)),
    .dec      (idle_dec),
    .expired  (idle_exp)
  );

  assign byte_timed = (state_q == ST_HDR1) || (state_q == ST_CHI) ||
                      (state_q == ST_CLO)  || (state_q == ST_CHK) ||
                      (state_q == ST_TAIL);
  assign fields_bad = (clo_q[7:6] == 2'b11) || (chi_q[1:0] == 2'b11);

  always_comb begin
    state_d       = state_q;
    chi_d         = chi_q;
    clo_d         = clo_q;
    chk_d         = chk_q;
    bps_div_d     = bps_div_q;
    data_size_d   = data_size_q;
    stop_size_d   = stop_size_q;
    parity_mode_d = parity_mode_q;
    cfg_update_d  = 1'b0;
    cfg_error_d   = 1'b0;
    err_code_d    = err_code_q;
    byte_load     = 1'b0;
    byte_dec      = 1'b0;
    idle_load     = 1'b0;
    idle_dec      = 1'b0;

    // A byte arriving on the expiry cycle wins over the timeout.
    if (byte_timed && !rx_valid) begin
      if (byte_exp) begin
        cfg_error_d = 1'b1;
        err_code_d  = ERR_TIMEOUT;
        state_d     = ST_HDR0;
      end else begin
        byte_dec = 1'b1;
      end
    end

    case (state_q)
      ST_HDR0: begin
        if (rx_valid) begin
          byte_load = 1'b1;
          if (rx_data == SOF0) state_d = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (rx_valid) begin
          byte_load = 1'b1;
          if (rx_data == SOF1)      state_d = ST_CHI;
          else if (rx_data == SOF0) state_d = ST_HDR1;
          else                      state_d = ST_HDR0;
        end
      end
      ST_CHI: begin
        if (rx_valid) begin
          byte_load = 1'b1;
          chi_d     = rx_data;
          state_d   = ST_CLO;
        end
      end
      ST_CLO: begin
        if (rx_valid) begin
          byte_load = 1'b1;
          clo_d     = rx_data;
          state_d   = ST_CHK;
        end
      end
      ST_CHK: begin
        if (rx_valid) begin
          byte_load = 1'b1;
          chk_d     = rx_data;
          state_d   = ST_TAIL;
        end
      end
      ST_TAIL: begin
        if (rx_valid) begin
          byte_load = 1'b1;
          if (rx_data != EOF) begin
            state_d = (rx_data == SOF0) ? ST_HDR1 : ST_HDR0;
          end else if (chk_q != (chi_q + clo_q)) begin
            cfg_error_d = 1'b1;
            err_code_d  = ERR_CHECKSUM;
            state_d     = ST_HDR0;
          end else if (fields_bad) begin
            cfg_error_d = 1'b1;
            err_code_d  = ERR_FIELD;
            state_d     = ST_HDR0;
          end else begin
            idle_load = 1'b1;
            state_d   = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (uart_idle) begin
          state_d = ST_APPLY;
        end else if (idle_exp) begin
          cfg_error_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = ST_HDR0;
        end else begin
          idle_dec = 1'b1;
        end
      end
      ST_APPLY: begin
        bps_div_d     = bps_lookup(clo_q[3:0]);
        data_size_d   = data_size_of(clo_q[5:4]);
        stop_size_d   = stop_size_of(clo_q[7:6]);
        parity_mode_d = chi_q[1:0];
        cfg_update_d  = 1'b1;
        err_code_d    = ERR_NONE;
        state_d       = ST_HDR0;
      end
      default: state_d = ST_HDR0;
    endcase

    cfg_req_d = (state_d == ST_WAIT_IDLE) || (state_d == ST_APPLY);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_HDR0;
      chi_q         <= '0;
      clo_q         <= '0;
      chk_q         <= '0;
      bps_div_q     <= RST_BPS_DIV;
      data_size_q   <= RST_DATA_SIZE;
      stop_size_q   <= RST_STOP_SIZE;
      parity_mode_q <= RST_PARITY_MODE;
      cfg_req_q     <= 1'b0;
      cfg_update_q  <= 1'b0;
      cfg_error_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      chi_q         <= chi_d;
      clo_q         <= clo_d;
      chk_q         <= chk_d;
      bps_div_q     <= bps_div_d;
      data_size_q   <= data_size_d;
      stop_size_q   <= stop_size_d;
      parity_mode_q <= parity_mode_d;
      cfg_req_q     <= cfg_req_d;
      cfg_update_q  <= cfg_update_d;
      cfg_error_q   <= cfg_error_d;
      err_code_q    <= err_code_d;
    end
  end

  assign cfg_req     = cfg_req_q;
  assign bps_div     = bps_div_q;
  assign data_size   = data_size_q;
  assign stop_size   = stop_size_q;
  assign parity_mode = parity_mode_q;
  assign cfg_update  = cfg_update_q;
  assign cfg_error   = cfg_error_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Directed bench for uart_cfg_ctrl: frame parsing, error paths, idle wait,
// timeouts and reset, with hand-computed expected configurations.
module tb_uart_cfg_ctrl;

  localparam int unsigned BT = 300;
  localparam int unsigned IT = 2000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        uart_idle = 1'b1;
  logic        cfg_req;
  logic [15:0] bps_div;
  logic [3:0]  data_size;
  logic [5:0]  stop_size;
  logic [1:0]  parity_mode;
  logic        cfg_update;
  logic        cfg_error;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;
  int upd_seen = 0;
  int err_seen = 0;

  uart_cfg_ctrl #(.BYTE_TIMEOUT(BT), .IDLE_TIMEOUT(IT)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .uart_idle   (uart_idle),
    .cfg_req     (cfg_req),
    .bps_div     (bps_div),
    .data_size   (data_size),
    .stop_size   (stop_size),
    .parity_mode (parity_mode),
    .cfg_update  (cfg_update),
    .cfg_error   (cfg_error),
    .err_code    (err_code)
  );

  // clock / reset
  always #5 clock = ~clock;

  // pulse counters, sampled shortly after each active edge
  always @(posedge clock) begin
    #1;
    if (cfg_update) upd_seen++;
    if (cfg_error)  err_seen++;
  end

  // drivers: called at a negedge, byte is sampled on the following posedge
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] chi, input logic [7:0] clo, input logic [7:0] chk);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(chi);
    send_byte(clo);
    send_byte(chk);
    send_byte(8'h55);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if ({bps_div, data_size, stop_size, parity_mode} !== {16'd325, 4'd8, 6'd16, 2'b00}) begin
      errors++;
      $display("FAIL reset_cfg got %h/%0d/%0d/%b want 325/8/16/00", bps_div, data_size, stop_size, parity_mode);
    end
    checks++;
    if ({cfg_req, cfg_update, cfg_error, err_code} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got req=%b upd=%b err=%b code=%0d want all 0", cfg_req, cfg_update, cfg_error, err_code);
    end
  endtask

  task automatic test_apply_timing;
    uart_idle = 1'b1;
    send_frame(8'h00, 8'hB6, 8'hB6);
    checks++;
    if ({cfg_req, cfg_update, bps_div, stop_size} !== {1'b1, 1'b0, 16'd325, 6'd16}) begin
      errors++;
      $display("FAIL apply_k got req=%b upd=%b stop=%0d want req=1 upd=0 stop=16", cfg_req, cfg_update, stop_size);
    end
    @(negedge clock);
    checks++;
    if ({cfg_req, cfg_update, stop_size} !== {1'b1, 1'b0, 6'd16}) begin
      errors++;
      $display("FAIL apply_k1 got req=%b upd=%b stop=%0d want req=1 upd=0 stop=16", cfg_req, cfg_update, stop_size);
    end
    @(negedge clock);
    checks++;
    if ({cfg_req, cfg_update} !== 2'b01) begin
      errors++;
      $display("FAIL apply_k2_flags got req=%b upd=%b want req=0 upd=1", cfg_req, cfg_update);
    end
    checks++;
    if ({bps_div, data_size, stop_size, parity_mode} !== {16'd325, 4'd8, 6'd32, 2'b00}) begin
      errors++;
      $display("FAIL apply_k2_cfg got %0d/%0d/%0d/%b want 325/8/32/00", bps_div, data_size, stop_size, parity_mode);
    end
    @(negedge clock);
    checks++;
    if (cfg_update !== 1'b0) begin
      errors++;
      $display("FAIL apply_pulse_width got upd=%b want 0", cfg_update);
    end
  endtask

  task automatic test_odd_parity;
    // CLO=0x49: baud 9, width 5, stop 24; CHI=0x01: odd parity
    send_frame(8'h01, 8'h49, 8'h4A);
    repeat (2) @(negedge clock);
    checks++;
    if ({bps_div, data_size, stop_size, parity_mode} !== {16'd81, 4'd5, 6'd24, 2'b01}) begin
      errors++;
      $display("FAIL odd_cfg got %0d/%0d/%0d/%b want 81/5/24/01", bps_div, data_size, stop_size, parity_mode);
    end
  endtask

  task automatic test_bad_checksum;
    int u0;
    u0 = upd_seen;
    send_frame(8'h00, 8'h0D, 8'h0E);
    checks++;
    if ({cfg_error, err_code, cfg_req} !== {1'b1, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL chk_err got err=%b code=%0d req=%b want err=1 code=1 req=0", cfg_error, err_code, cfg_req);
    end
    repeat (3) @(negedge clock);
    checks++;
    if ({cfg_error, bps_div, data_size, stop_size, parity_mode} !== {1'b0, 16'd81, 4'd5, 6'd24, 2'b01} || upd_seen != u0) begin
      errors++;
      $display("FAIL chk_hold got err=%b cfg=%0d/%0d/%0d/%b upds=%0d want 0 81/5/24/01 0", cfg_error, bps_div, data_size, stop_size, parity_mode, upd_seen - u0);
    end
  endtask

  task automatic test_bad_fields;
    send_frame(8'h00, 8'hC0, 8'hC0);
    checks++;
    if ({cfg_error, err_code} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL stop11 got err=%b code=%0d want err=1 code=2", cfg_error, err_code);
    end
    @(negedge clock);
    send_frame(8'h03, 8'h00, 8'h03);
    checks++;
    if ({cfg_error, err_code} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL parity11 got err=%b code=%0d want err=1 code=2", cfg_error, err_code);
    end
  endtask

  task automatic test_resync;
    logic [7:0] seq [8];
    seq = '{8'h12, 8'hAA, 8'hAA, 8'h55, 8'h00, 8'h0F, 8'h0F, 8'h55};
    for (int i = 0; i < 8; i++) send_byte(seq[i]);
    repeat (2) @(negedge clock);
    checks++;
    if ({bps_div, data_size, stop_size, parity_mode, err_code} !== {16'd12, 4'd5, 6'd16, 2'b00, 2'd0}) begin
      errors++;
      $display("FAIL resync got %0d/%0d/%0d/%b code=%0d want 12/5/16/00 code=0", bps_div, data_size, stop_size, parity_mode, err_code);
    end
  endtask

  task automatic test_back_to_back;
    // tail byte 0xAA restarts a header; CLO=0x7C: baud 12, width 8, stop 24; CHI=0x02: even
    logic [7:0] seq [11];
    int e0;
    e0 = err_seen;
    seq = '{8'hAA, 8'h55, 8'h00, 8'h3A, 8'h3A, 8'hAA, 8'h55, 8'h02, 8'h7C, 8'h7E, 8'h55};
    for (int i = 0; i < 11; i++) send_byte(seq[i]);
    repeat (2) @(negedge clock);
    checks++;
    if ({bps_div, data_size, stop_size, parity_mode} !== {16'd54, 4'd8, 6'd24, 2'b10} || err_seen != e0) begin
      errors++;
      $display("FAIL tail_resync got %0d/%0d/%0d/%b errs=%0d want 54/8/24/10 errs=0", bps_div, data_size, stop_size, parity_mode, err_seen - e0);
    end
  endtask

  task automatic test_idle_wait;
    int low_cnt;
    low_cnt = 0;
    uart_idle = 1'b0;
    send_frame(8'h00, 8'hB6, 8'hB6);
    repeat (1000) begin
      @(negedge clock);
      if (cfg_req !== 1'b1 || cfg_update !== 1'b0) low_cnt++;
    end
    checks++;
    if (low_cnt != 0 || bps_div !== 16'd54) begin
      errors++;
      $display("FAIL idle_hold got %0d bad cycles bps=%0d want 0 bad cycles bps=54", low_cnt, bps_div);
    end
    uart_idle = 1'b1;
    @(negedge clock);
    checks++;
    if ({cfg_req, cfg_update} !== 2'b10) begin
      errors++;
      $display("FAIL idle_apply1 got req=%b upd=%b want req=1 upd=0", cfg_req, cfg_update);
    end
    @(negedge clock);
    checks++;
    if ({cfg_req, cfg_update, bps_div, data_size, stop_size, parity_mode} !== {1'b0, 1'b1, 16'd325, 4'd8, 6'd32, 2'b00}) begin
      errors++;
      $display("FAIL idle_apply2 got req=%b upd=%b cfg=%0d/%0d/%0d/%b want 0 1 325/8/32/00", cfg_req, cfg_update, bps_div, data_size, stop_size, parity_mode);
    end
  endtask

  task automatic test_idle_timeout;
    int bad_cnt;
    int u0;
    bad_cnt = 0;
    u0 = upd_seen;
    uart_idle = 1'b0;
    send_frame(8'h01, 8'h49, 8'h4A);
    repeat (IT - 1) begin
      @(negedge clock);
      if (cfg_error !== 1'b0 || cfg_req !== 1'b1) bad_cnt++;
    end
    checks++;
    if (bad_cnt != 0) begin
      errors++;
      $display("FAIL idle_to_early got %0d bad cycles want 0", bad_cnt);
    end
    @(negedge clock);
    checks++;
    if ({cfg_error, err_code, cfg_req} !== {1'b1, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL idle_to got err=%b code=%0d req=%b want err=1 code=3 req=0", cfg_error, err_code, cfg_req);
    end
    uart_idle = 1'b1;
    repeat (4) @(negedge clock);
    checks++;
    if ({bps_div, data_size, stop_size, parity_mode} !== {16'd325, 4'd8, 6'd32, 2'b00} || upd_seen != u0) begin
      errors++;
      $display("FAIL idle_to_hold got %0d/%0d/%0d/%b upds=%0d want 325/8/32/00 upds=0", bps_div, data_size, stop_size, parity_mode, upd_seen - u0);
    end
  endtask

  task automatic test_byte_gap_edge;
    // next byte lands on the exact expiry cycle: must still be accepted
    int e0;
    e0 = err_seen;
    send_byte(8'hAA);
    send_byte(8'h55);
    repeat (BT - 1) @(negedge clock);
    send_byte(8'h00);
    send_byte(8'h0D);
    send_byte(8'h0D);
    send_byte(8'h55);
    repeat (2) @(negedge clock);
    checks++;
    if ({bps_div, data_size, stop_size, parity_mode} !== {16'd27, 4'd5, 6'd16, 2'b00} || err_seen != e0) begin
      errors++;
      $display("FAIL gap_edge got %0d/%0d/%0d/%b errs=%0d want 27/5/16/00 errs=0", bps_div, data_size, stop_size, parity_mode, err_seen - e0);
    end
  endtask

  task automatic test_byte_timeout;
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h00);
    repeat (BT - 1) @(negedge clock);
    checks++;
    if (cfg_error !== 1'b0) begin
      errors++;
      $display("FAIL byte_to_early got err=%b want 0", cfg_error);
    end
    @(negedge clock);
    checks++;
    if ({cfg_error, err_code} !== {1'b1, 2'd3}) begin
      errors++;
      $display("FAIL byte_to got err=%b code=%0d want err=1 code=3", cfg_error, err_code);
    end
    @(negedge clock);
    send_frame(8'h01, 8'h49, 8'h4A);
    repeat (2) @(negedge clock);
    checks++;
    if ({bps_div, data_size, stop_size, parity_mode, err_code} !== {16'd81, 4'd5, 6'd24, 2'b01, 2'd0}) begin
      errors++;
      $display("FAIL byte_to_recover got %0d/%0d/%0d/%b code=%0d want 81/5/24/01 code=0", bps_div, data_size, stop_size, parity_mode, err_code);
    end
  endtask

  task automatic test_reset_in_wait;
    int u0;
    int e0;
    u0 = upd_seen;
    e0 = err_seen;
    uart_idle = 1'b0;
    send_frame(8'h00, 8'h0D, 8'h0D);
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    checks++;
    if ({bps_div, data_size, stop_size, parity_mode, cfg_req, err_code} !== {16'd325, 4'd8, 6'd16, 2'b00, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL rst_wait got %0d/%0d/%0d/%b req=%b code=%0d want 325/8/16/00 req=0 code=0", bps_div, data_size, stop_size, parity_mode, cfg_req, err_code);
    end
    uart_idle = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    checks++;
    if (upd_seen != u0 || err_seen != e0 || bps_div !== 16'd325) begin
      errors++;
      $display("FAIL rst_wait_pulses got upds=%0d errs=%0d bps=%0d want 0 0 325", upd_seen - u0, err_seen - e0, bps_div);
    end
  endtask

  initial begin
    test_reset;
    test_apply_timing;
    test_odd_parity;
    test_bad_checksum;
    test_bad_fields;
    test_resync;
    test_back_to_back;
    test_idle_wait;
    test_idle_timeout;
    test_byte_gap_edge;
    test_byte_timeout;
    test_reset_in_wait;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
